// File: rtl/bcdbin8.sv
// 3-digit packed BCD (0..255) to 8-bit binary converter using a serial
// shift-right / subtract-3 algorithm; out-of-range operands saturate to 8'hFF.
module bcdbin8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] bcd,
    output logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [17:0] w_r, w_s, shifted_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        bad_r, bad_s;
    logic [7:0]  bin_r, bin_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;

    // Digit correction after a right shift: a nibble that received the
    // weight-8 bit from the digit above must lose 3 (8 -> 5), without borrow.
    function automatic logic [3:0] sub3(input logic [3:0] n);
        sub3 = (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    // True for malformed digits or values above 255.
    function automatic logic bcd_bad(input logic [9:0] v);
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = v[9:8];
        t = v[7:4];
        o = v[3:0];
        bcd_bad = (o > 4'd9) || (t > 4'd9) || (h == 2'd3) ||
                  ((h == 2'd2) && (t > 4'd5)) ||
                  ((h == 2'd2) && (t == 4'd5) && (o > 4'd5));
    endfunction

    // Next-state and datapath logic.
    always_comb begin
        state_s   = state_r;
        w_s       = w_r;
        cnt_s     = cnt_r;
        bad_s     = bad_r;
        bin_s     = bin_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = err_r;
        shifted_s = {1'b0, w_r[17:1]};
        case (state_r)
            IDLE: begin
                if (start && !busy_r) begin
                    w_s     = {bcd, 8'h00};
                    cnt_s   = 3'd0;
                    bad_s   = bcd_bad(bcd);
                    busy_s  = 1'b1;
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                w_s = {shifted_s[17:16], sub3(shifted_s[15:12]),
                       sub3(shifted_s[11:8]), shifted_s[7:0]};
                if (cnt_r == 3'd7) begin
                    bin_s   = bad_r ? 8'hFF : w_s[7:0];
                    err_s   = bad_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    cnt_s   = 3'd0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            w_r     <= 18'd0;
            cnt_r   <= 3'd0;
            bad_r   <= 1'b0;
            bin_r   <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            w_r     <= w_s;
            cnt_r   <= cnt_s;
            bad_r   <= bad_s;
            bin_r   <= bin_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign bin  = bin_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcdbin8.sv
// Directed and exhaustive checks for bcdbin8 against an arithmetic BCD model.
module tb_bcdbin8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] bcd;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks;
    int n_fail;

    bcdbin8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int ref_val(input logic [9:0] v);
        ref_val = int'(v[9:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int ref_err(input logic [9:0] v);
        ref_err = (v[3:0] > 4'd9 || v[7:4] > 4'd9 || ref_val(v) > 255) ? 1 : 0;
    endfunction

    // Issue one start, then wait (bounded) for done; returns cycles and busy count.
    task automatic run_one(input logic [9:0] v, output int lat, output int busy_cnt);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int seen;
        logic [9:0] v;
        logic [9:0] dir_in  [3];
        int         dir_exp [3];

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bcd      = 10'h000;
        #2;
        check("reset_bin", int'(bin), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 255 boundary: latency, busy length, single-cycle done.
        run_one(10'h255, lat, bc);
        check("lat_255", lat, 8);
        check("busy_cycles_255", bc, 8);
        check("bin_255", int'(bin), 8'hFF);
        check("err_255", int'(err), 0);
        check("busy_at_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("bin_held", int'(bin), 8'hFF);

        dir_in[0] = 10'h128; dir_exp[0] = 8'h80;
        dir_in[1] = 10'h000; dir_exp[1] = 8'h00;
        dir_in[2] = 10'h099; dir_exp[2] = 8'h63;
        for (int i = 0; i < 3; i++) begin
            run_one(dir_in[i], lat, bc);
            check($sformatf("lat_%0h", dir_in[i]), lat, 8);
            check($sformatf("bin_%0h", dir_in[i]), int'(bin), dir_exp[i]);
            check($sformatf("err_%0h", dir_in[i]), int'(err), 0);
        end

        run_one(10'h256, lat, bc);
        check("lat_256", lat, 8);
        check("bin_256", int'(bin), 8'hFF);
        check("err_256", int'(err), 1);
        run_one(10'h1A3, lat, bc);
        check("err_1A3", int'(err), 1);
        check("bin_1A3", int'(bin), 8'hFF);
        run_one(10'h300, lat, bc);
        check("err_300", int'(err), 1);
        run_one(10'h000, lat, bc);
        check("err_cleared", int'(err), 0);

        // Back-to-back with start held high; bcd perturbed while busy.
        @(negedge clk);
        bcd   = 10'h010;
        start = 1'b1;
        @(posedge clk);
        #1;
        bcd = 10'h020;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat1", lat, 8);
        check("b2b_bin1", int'(bin), 8'h0A);
        @(posedge clk);
        #1;
        bcd = 10'h099;
        check("b2b_busy_again", int'(busy), 1);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_period", lat, 9);
        check("b2b_bin2", int'(bin), 8'h14);
        start = 1'b0;
        seen  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("no_spurious_done", seen, 0);

        // Reset mid-conversion.
        @(negedge clk);
        bcd   = 10'h077;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bin", int'(bin), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        run_one(10'h042, lat, bc);
        check("post_reset_lat", lat, 8);
        check("post_reset_bin", int'(bin), 8'h2A);
        check("post_reset_err", int'(err), 0);

        // Exhaustive sweep of every 10-bit code.
        for (int c = 0; c < 1024; c++) begin
            v = c[9:0];
            run_one(v, lat, bc);
            check($sformatf("sweep_lat_%0h", v), lat, 8);
            check($sformatf("sweep_err_%0h", v), int'(err), ref_err(v));
            check($sformatf("sweep_bin_%0h", v), int'(bin),
                  (ref_err(v) != 0) ? 255 : ref_val(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcdbin8.md
BCDBIN8 -- requirements
Module: bcdbin8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled on each rising edge of clk.
REQ-005 bcd  input  10  3-digit packed BCD operand: [9:8] hundreds, [7:4] tens, [3:0] ones; sampled only when a start is accepted.
REQ-006 bin  output  8  registered binary result; holds its value between conversions.
REQ-007 busy  output  1  registered; high while a conversion is in progress.
REQ-008 done  output  1  registered; single-cycle completion pulse.
REQ-009 err  output  1  registered; invalid or out-of-range operand flag, valid while done=1 and held until the next completion.

Function
REQ-010 The block SHALL use two states: IDLE and CONV.
REQ-011 Accept rule: a start SHALL be accepted when start=1 and busy=0 at a rising edge. This includes the edge on which done=1.
REQ-012 On accept (edge E0): load the 18-bit work register w with {bcd, 8'h00}, clear the 3-bit shift counter, capture the range check, set busy=1, and move to CONV.
REQ-013 While busy=1, start SHALL be ignored and bcd changes SHALL have no effect.
REQ-014 Each CONV edge SHALL shift w right by 1, filling the MSB with 0.
REQ-015 After each shift, each of w[11:8] (ones) and w[15:12] (tens) SHALL have 3 subtracted if its value is >= 8. The two corrections are independent and use the post-shift values.
REQ-016 Exactly 8 shift edges SHALL occur (E1..E8).
REQ-017 At E8 the block SHALL: load bin from w[7:0] (or 8'hFF if the error condition holds), update err, set done=1, clear busy, and return to IDLE.
REQ-018 Latency SHALL be 8 cycles from the accepting edge to done=1.
REQ-019 Throughput SHALL be one conversion per 9 cycles (back-to-back start).
REQ-020 done SHALL be high for exactly one cycle per accepted start. It SHALL never assert without a preceding accepted start.
REQ-021 The error condition SHALL be evaluated on the captured operand and is true when any of the following holds:
  - ones > 9;
  - tens > 9;
  - hundreds = 3;
  - hundreds = 2 and tens > 5;
  - hundreds = 2, tens = 5 and ones > 5.
REQ-022 On error, the conversion SHALL still take the full 8 cycles, bin SHALL saturate to 8'hFF, and err SHALL be 1. Otherwise err SHALL be 0.
REQ-023 For every valid operand 0..255, bin SHALL equal the decimal value of bcd.
REQ-024 Widths: the subtract-3 arithmetic SHALL be 4-bit with no borrow into adjacent nibbles. The counter SHALL wrap from 7 only via the state exit.

Reset
REQ-025 While rst_n=0, regardless of clk: state=IDLE, w=0, counter=0, bin=8'h00, busy=0, done=0, err=0.
REQ-026 A reset asserted mid-conversion SHALL abort it with no done pulse.
REQ-027 After rst_n deasserts, the first start SHALL be accepted normally.

Verification
REQ-028 bcd=10'h255, start 1 cycle -> busy=1 for 8 cycles; done=1 on the 8th edge after accept; bin=8'hFF (255), err=0.
REQ-029 Directed operands -> required results:
  - bcd=10'h128 -> bin=8'h80, err=0;
  - bcd=10'h000 -> bin=8'h00, err=0;
  - bcd=10'h099 -> bin=8'h63, err=0.
REQ-030 Error operands -> required results:
  - bcd=10'h256 -> bin=8'hFF, err=1;
  - bcd=10'h1A3 -> err=1;
  - bcd=10'h300 -> err=1.
REQ-031 start held high continuously, operands 10'h010 then 10'h020 -> results 8'h0A then 8'h14; done pulses 9 cycles apart; bcd changes while busy do not affect the result.
REQ-032 rst_n pulsed low at the 4th CONV cycle -> all outputs 0 immediately and no done; a subsequent start with 10'h042 -> bin=8'h2A after 8 cycles.
REQ-033 An exhaustive sweep of all 1024 bcd codes SHALL match a reference model: value and err for every code, and bin=8'hFF whenever err=1.
